// File: rtl/requant_packer.sv
// Requantizes 24-bit MAC accumulations to INT8/INT4 and packs them into 256-bit activation words.
// Optional saturation statistics counter is built when REQUANT_SAT_STATS_EN is defined.
module requant_packer #(
  parameter int PSUM_W  = 24,
  parameter int DATA_W  = 256,
  parameter int SHIFT_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [PSUM_W-1:0]  i_data,
  input  logic [1:0]         i_mode,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic               i_last,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_W-1:0]  o_data,
  output logic [6:0]         o_lanes,
  output logic               o_last,
  output logic [1:0]         o_mode,
  output logic [15:0]        o_sat_cnt
);

  // Headroom for the x256 compensation plus the rounding addend.
  localparam int X_W = PSUM_W + 10;
  localparam logic signed [X_W-1:0] I8_MAX = X_W'(127);
  localparam logic signed [X_W-1:0] I8_MIN = X_W'(-128);
  localparam logic signed [X_W-1:0] I4_MAX = X_W'(7);
  localparam logic signed [X_W-1:0] I4_MIN = X_W'(-8);

  logic [6:0]        lane_cnt;
  logic [1:0]        word_mode;
  logic [DATA_W-1:0] pack_buf;
  logic [DATA_W-1:0] buf_next;

  logic              accept;
  logic              close;
  logic [1:0]        eff_mode;
  logic              is_int8;
  logic signed [X_W-1:0] x;
  logic signed [X_W-1:0] rnd;
  logic signed [X_W-1:0] y;
  logic [7:0]        lane_val;
  logic              sat;
  logic              last_lane;

  assign o_ready = ~o_valid | i_ready;
  assign accept  = i_valid & o_ready;

  always_comb begin
    eff_mode = (lane_cnt == 7'd0) ? i_mode : word_mode;
    is_int8  = (eff_mode == 2'd0);

    x = {{(X_W-PSUM_W){i_data[PSUM_W-1]}}, i_data};
    if (eff_mode[1])
      x = x <<< 8;
    rnd = '0;
    if (i_shift != '0)
      rnd = X_W'(1) << (i_shift - 1'b1);
    y = (x + rnd) >>> i_shift;

    sat      = 1'b0;
    lane_val = y[7:0];
    if (is_int8) begin
      if (y > I8_MAX) begin
        lane_val = 8'h7F;
        sat      = 1'b1;
      end else if (y < I8_MIN) begin
        lane_val = 8'h80;
        sat      = 1'b1;
      end
    end else begin
      if (y > I4_MAX) begin
        lane_val = 8'h07;
        sat      = 1'b1;
      end else if (y < I4_MIN) begin
        lane_val = 8'h08;
        sat      = 1'b1;
      end
    end

    buf_next = pack_buf;
    if (is_int8)
      buf_next[{lane_cnt[4:0], 3'b000} +: 8] = lane_val;
    else
      buf_next[{lane_cnt[5:0], 2'b00} +: 4] = lane_val[3:0];

    last_lane = is_int8 ? (lane_cnt == 7'd31) : (lane_cnt == 7'd63);
    close     = accept & (i_last | last_lane);
  end

  // A closing accept can only happen while the output slot is free or being drained.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_lanes   <= '0;
      o_last    <= 1'b0;
      o_mode    <= '0;
      lane_cnt  <= '0;
      word_mode <= '0;
      pack_buf  <= '0;
    end else begin
      if (close) begin
        o_valid  <= 1'b1;
        o_data   <= buf_next;
        o_lanes  <= lane_cnt + 7'd1;
        o_last   <= i_last;
        o_mode   <= eff_mode;
        lane_cnt <= '0;
        pack_buf <= '0;
      end else begin
        if (i_ready)
          o_valid <= 1'b0;
        if (accept) begin
          pack_buf <= buf_next;
          lane_cnt <= lane_cnt + 7'd1;
        end
      end
      if (accept && lane_cnt == 7'd0)
        word_mode <= i_mode;
    end
  end

`ifdef REQUANT_SAT_STATS_EN
  logic [15:0] sat_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      sat_cnt <= '0;
    else if (accept && sat && sat_cnt != 16'hFFFF)
      sat_cnt <= sat_cnt + 16'd1;
  end

  assign o_sat_cnt = sat_cnt;
`else
  logic sat_unused;
  assign sat_unused = sat;
  assign o_sat_cnt  = '0;
`endif

endmodule
